// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl
//   Sequences the weight buffer. The load side slices a DDR beat stream into
//   per-bank-group write strobes/addresses. The read side arbitrates kernel-set
//   requests from the PE scheduler. It holds back any set that is not resident
//   yet, issues rd_conf with the set's start address, and reports completion
//   when the buffer raises ker_en.
//   Optional build macro: WBC_PERF_CNT_EN adds a saturating stall counter
//   (stall_cnt) and its clear input (stall_clr).
module weight_buffer_ctrl #(
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 64,
    parameter int DDR_DATA_LEN = 256,
    parameter int BUFFER_NUM   = 32,
    parameter int SET_DEPTH    = 10,
    parameter int SET_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic [ADDR_LEN-1:0]     load_base,
    input  logic [SET_W-1:0]        load_sets,
    input  logic                    ddr_valid,
    input  logic [DDR_DATA_LEN-1:0] ddr_data,
    output logic                    ddr_ready,
    output logic [DDR_DATA_LEN-1:0] wr_data,
    output logic [ADDR_LEN-1:0]     wr_addr,
    output logic [BUFFER_NUM-1:0]   wr_en,
    output logic                    load_busy,
    output logic [SET_W-1:0]        sets_loaded,
    input  logic                    ker_req,
    input  logic [SET_W-1:0]        ker_set_idx,
    output logic                    ker_grant,
    output logic                    rd_conf,
    output logic [ADDR_LEN-1:0]     st_rd_addr,
    input  logic                    buf_idle,
    input  logic                    ker_en,
    output logic                    ker_done,
    output logic                    req_err
`ifdef WBC_PERF_CNT_EN
    ,
    input  logic                    stall_clr,
    output logic [31:0]             stall_cnt
`endif
);

    // One DDR beat feeds GRP banks; the buffer is NGRP such groups wide.
    localparam int GRP  = DDR_DATA_LEN / DATA_LEN;
    localparam int NGRP = BUFFER_NUM / GRP;
    localparam int G_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int D_W  = (SET_DEPTH > 1) ? $clog2(SET_DEPTH) : 1;

    typedef enum logic {
        L_IDLE,
        L_RUN
    } load_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_CONF,
        R_WAIT
    } rd_state_t;

    // ------------------------------------------------------------------
    // Load side
    // ------------------------------------------------------------------
    load_state_t             load_state_reg, load_state_next;
    logic [ADDR_LEN-1:0]     base_reg;
    logic [SET_W-1:0]        sets_reg;
    logic [SET_W-1:0]        sets_loaded_reg;
    logic [G_W-1:0]          g_reg;
    logic [D_W-1:0]          depth_reg;
    logic [ADDR_LEN-1:0]     addr_off_reg;
    logic [DDR_DATA_LEN-1:0] wr_data_reg;
    logic [ADDR_LEN-1:0]     wr_addr_reg;
    logic [BUFFER_NUM-1:0]   wr_en_reg;

    logic                    load_capture;
    logic                    beat_accept;
    logic                    g_last;
    logic                    depth_last;
    logic                    set_last;
    logic                    last_beat;
    logic [NGRP-1:0]         grp_sel;
    logic [BUFFER_NUM-1:0]   wr_en_mask;

    assign g_last     = (g_reg == G_W'(NGRP - 1));
    assign depth_last = (depth_reg == D_W'(SET_DEPTH - 1));
    assign set_last   = ((sets_loaded_reg + SET_W'(1)) == sets_reg);
    assign last_beat  = g_last && depth_last && set_last;

    // Strobe of the bank group currently being filled: GRP ones per group.
    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            assign grp_sel[gi]                = (g_reg == G_W'(gi));
            assign wr_en_mask[gi*GRP +: GRP]  = {GRP{grp_sel[gi]}};
        end
    endgenerate

    // Load FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_state_reg <= L_IDLE;
        end else begin
            load_state_reg <= load_state_next;
        end
    end

    // Load FSM next state; a zero-set load is a no-op and start is ignored while running.
    always_comb begin
        load_state_next = load_state_reg;
        load_capture    = 1'b0;
        beat_accept     = 1'b0;
        case (load_state_reg)
            L_IDLE: begin
                if (load_start && (load_sets != '0)) begin
                    load_capture    = 1'b1;
                    load_state_next = L_RUN;
                end
            end
            L_RUN: begin
                beat_accept = ddr_valid;
                if (ddr_valid && last_beat) begin
                    load_state_next = L_IDLE;
                end
            end
            default: load_state_next = L_IDLE;
        endcase
    end

    // Load datapath: capture, beat slicing and group/address/set counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_reg        <= '0;
            sets_reg        <= '0;
            sets_loaded_reg <= '0;
            g_reg           <= '0;
            depth_reg       <= '0;
            addr_off_reg    <= '0;
            wr_data_reg     <= '0;
            wr_addr_reg     <= '0;
            wr_en_reg       <= '0;
        end else begin
            wr_en_reg <= beat_accept ? wr_en_mask : '0;
            if (load_capture) begin
                base_reg        <= load_base;
                sets_reg        <= load_sets;
                sets_loaded_reg <= '0;
                g_reg           <= '0;
                depth_reg       <= '0;
                addr_off_reg    <= '0;
            end else if (beat_accept) begin
                wr_data_reg <= ddr_data;
                wr_addr_reg <= base_reg + addr_off_reg;
                if (g_last) begin
                    g_reg        <= '0;
                    addr_off_reg <= addr_off_reg + ADDR_LEN'(1);
                    if (depth_last) begin
                        depth_reg       <= '0;
                        sets_loaded_reg <= sets_loaded_reg + SET_W'(1);
                    end else begin
                        depth_reg <= depth_reg + D_W'(1);
                    end
                end else begin
                    g_reg <= g_reg + G_W'(1);
                end
            end
        end
    end

    assign ddr_ready   = (load_state_reg == L_RUN);
    assign load_busy   = (load_state_reg == L_RUN);
    assign wr_data     = wr_data_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_en       = wr_en_reg;
    assign sets_loaded = sets_loaded_reg;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t           rd_state_reg, rd_state_next;
    logic                ker_grant_reg;
    logic                req_err_reg;
    logic                rd_conf_reg;
    logic                ker_done_reg;
    logic [ADDR_LEN-1:0] st_rd_addr_reg;

    logic                req_pending;
    logic                req_seen;
    logic                req_bad;
    logic                req_go;
    logic [ADDR_LEN-1:0] set_off;

    assign set_off = ADDR_LEN'(ker_set_idx) * ADDR_LEN'(SET_DEPTH);

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_reg <= R_IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
        end
    end

    // Read FSM next state and request decode. The request still visible in the
    // grant cycle is the one just answered, so it is not evaluated again; a
    // load captured this cycle makes the request wait for the new set count.
    // buf_idle is only sampled in R_IDLE, so its lag after rd_conf is harmless.
    always_comb begin
        rd_state_next = rd_state_reg;
        req_pending   = 1'b0;
        req_seen      = 1'b0;
        req_bad       = 1'b0;
        req_go        = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                req_pending = ker_req && !ker_grant_reg;
                req_seen    = req_pending && !load_capture;
                req_bad     = req_seen && (ker_set_idx >= sets_reg);
                req_go      = req_seen && !req_bad &&
                              (ker_set_idx < sets_loaded_reg) && buf_idle;
                if (req_go) begin
                    rd_state_next = R_CONF;
                end
            end
            R_CONF: begin
                rd_state_next = R_WAIT;
            end
            R_WAIT: begin
                if (ker_en) begin
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    // Read pulses and the start address handed to the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ker_grant_reg  <= 1'b0;
            req_err_reg    <= 1'b0;
            rd_conf_reg    <= 1'b0;
            ker_done_reg   <= 1'b0;
            st_rd_addr_reg <= '0;
        end else begin
            ker_grant_reg <= req_go || req_bad;
            req_err_reg   <= req_bad;
            rd_conf_reg   <= (rd_state_reg == R_CONF);
            ker_done_reg  <= (rd_state_reg == R_WAIT) && ker_en;
            if (req_go) begin
                st_rd_addr_reg <= base_reg + set_off;
            end
        end
    end

    assign ker_grant  = ker_grant_reg;
    assign req_err    = req_err_reg;
    assign rd_conf    = rd_conf_reg;
    assign ker_done   = ker_done_reg;
    assign st_rd_addr = st_rd_addr_reg;

`ifdef WBC_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Stall counter: cycles a request sits in R_IDLE without being answered.
    // ------------------------------------------------------------------
    logic        stall_inc;
    logic [31:0] stall_cnt_reg;

    assign stall_inc = req_pending && !req_bad && !req_go;

    // Saturating stall count; clear takes priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (stall_clr) begin
            stall_cnt_reg <= '0;
        end else if (stall_inc && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Directed testbench for weight_buffer_ctrl: load sequencing, address wrap,
// gated reads, request rejection, buf_idle stalls and mid-load reset.
module tb_weight_buffer_ctrl;

    logic         clk;
    logic         rst_n;
    logic         load_start;
    logic [15:0]  load_base;
    logic [7:0]   load_sets;
    logic         ddr_valid;
    logic [255:0] ddr_data;
    logic         ddr_ready;
    logic [255:0] wr_data;
    logic [15:0]  wr_addr;
    logic [31:0]  wr_en;
    logic         load_busy;
    logic [7:0]   sets_loaded;
    logic         ker_req;
    logic [7:0]   ker_set_idx;
    logic         ker_grant;
    logic         rd_conf;
    logic [15:0]  st_rd_addr;
    logic         buf_idle;
    logic         ker_en;
    logic         ker_done;
    logic         req_err;
`ifdef WBC_PERF_CNT_EN
    logic         stall_clr;
    logic [31:0]  stall_cnt;
`endif

    int n_checks;
    int n_fail;

    weight_buffer_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_sets   (load_sets),
        .ddr_valid   (ddr_valid),
        .ddr_data    (ddr_data),
        .ddr_ready   (ddr_ready),
        .wr_data     (wr_data),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .load_busy   (load_busy),
        .sets_loaded (sets_loaded),
        .ker_req     (ker_req),
        .ker_set_idx (ker_set_idx),
        .ker_grant   (ker_grant),
        .rd_conf     (rd_conf),
        .st_rd_addr  (st_rd_addr),
        .buf_idle    (buf_idle),
        .ker_en      (ker_en),
        .ker_done    (ker_done),
        .req_err     (req_err)
`ifdef WBC_PERF_CNT_EN
        ,
        .stall_clr   (stall_clr),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [15:0] base, input logic [7:0] sets);
        load_start = 1'b1;
        load_base  = base;
        load_sets  = sets;
        tick();
        load_start = 1'b0;
    endtask

    // Feed n beats; with gap set, an idle cycle follows every beat.
    task automatic run_beats(input logic [15:0] base, input int n, input bit gap);
        logic [31:0]  en_exp;
        logic [15:0]  addr_exp;
        logic [255:0] data_exp;
        logic [7:0]   sets_exp;
        for (int b = 0; b < n; b++) begin
            data_exp  = {8{32'(b) ^ 32'hA5A5_0000}};
            ddr_valid = 1'b1;
            ddr_data  = data_exp;
            tick();
            en_exp   = 32'h0000_000F;
            en_exp   = en_exp << (4 * (b % 8));
            addr_exp = base + 16'(b / 8);
            sets_exp = 8'((b + 1) / 80);
            chk("beat_wr_en", wr_en, en_exp);
            chk("beat_wr_addr", wr_addr, addr_exp);
            chk("beat_wr_data", wr_data, data_exp);
            chk("beat_sets_loaded", sets_loaded, sets_exp);
            chk("beat_no_grant", ker_grant, 1'b0);
            if (gap) begin
                ddr_valid = 1'b0;
                tick();
                chk("gap_wr_en", wr_en, 32'h0);
            end
        end
        ddr_valid = 1'b0;
        $display("load base=%04h beats=%0d gap=%0d sets_loaded=%0d", base, n, gap, sets_loaded);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        load_start  = 1'b0;
        load_base   = '0;
        load_sets   = '0;
        ddr_valid   = 1'b0;
        ddr_data    = '0;
        ker_req     = 1'b0;
        ker_set_idx = '0;
        buf_idle    = 1'b1;
        ker_en      = 1'b0;
`ifdef WBC_PERF_CNT_EN
        stall_clr   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_ddr_ready", ddr_ready, 1'b0);
        chk("rst_wr_en", wr_en, 32'h0);
        chk("rst_sets_loaded", sets_loaded, 8'h0);
        chk("rst_grant", ker_grant, 1'b0);
        chk("rst_rd_conf", rd_conf, 1'b0);
        chk("rst_st_rd_addr", st_rd_addr, 16'h0);
        rst_n = 1'b1;
        tick();

        // Zero-set load is a no-op.
        start_load(16'h0100, 8'd0);
        chk("zero_load_busy", load_busy, 1'b0);

        // Continuous 2-set load.
        start_load(16'h0100, 8'd2);
        chk("t1_busy", load_busy, 1'b1);
        chk("t1_ready", ddr_ready, 1'b1);
        run_beats(16'h0100, 160, 1'b0);
        chk("t1_ready_fall", ddr_ready, 1'b0);
        chk("t1_sets_final", sets_loaded, 8'd2);
        tick();
        chk("t1_idle_wr_en", wr_en, 32'h0);

        // Same load with ddr_valid toggling.
        start_load(16'h0100, 8'd2);
        run_beats(16'h0100, 160, 1'b1);
        chk("t2_ready_fall", ddr_ready, 1'b0);

        // Request for set 1 issued together with load_start: waits for both sets.
        ker_req     = 1'b1;
        ker_set_idx = 8'd1;
        start_load(16'h0100, 8'd2);
        chk("t3_sets_cleared", sets_loaded, 8'd0);
        run_beats(16'h0100, 160, 1'b0);
        chk("t3_grant_wait", ker_grant, 1'b0);
        tick();
        chk("t3_grant", ker_grant, 1'b1);
        chk("t3_st_addr", st_rd_addr, 16'h010A);
        chk("t3_rd_conf_early", rd_conf, 1'b0);
        chk("t3_no_err", req_err, 1'b0);
        ker_req = 1'b0;
        tick();
        chk("t3_rd_conf", rd_conf, 1'b1);
        chk("t3_grant_pulse", ker_grant, 1'b0);
        ker_en = 1'b1;
        tick();
        ker_en = 1'b0;
        chk("t3_ker_done", ker_done, 1'b1);
        chk("t3_rd_conf_once", rd_conf, 1'b0);
        tick();
        chk("t3_ker_done_pulse", ker_done, 1'b0);
        $display("read idx=1 st_rd_addr=%04h", st_rd_addr);

        // Out-of-range request: error and grant together, no rd_conf.
        ker_req     = 1'b1;
        ker_set_idx = 8'd3;
        tick();
        chk("t4_grant", ker_grant, 1'b1);
        chk("t4_req_err", req_err, 1'b1);
        ker_req = 1'b0;
        tick();
        chk("t4_err_pulse", req_err, 1'b0);
        chk("t4_grant_pulse", ker_grant, 1'b0);
        chk("t4_no_rd_conf", rd_conf, 1'b0);
        chk("t4_st_hold", st_rd_addr, 16'h010A);
        tick();
        chk("t4_no_rd_conf2", rd_conf, 1'b0);
        $display("read idx=3 rejected");

        // buf_idle low blocks the grant.
        buf_idle    = 1'b0;
        ker_req     = 1'b1;
        ker_set_idx = 8'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_blocked", ker_grant, 1'b0);
        end
        buf_idle = 1'b1;
        tick();
        chk("t5_grant", ker_grant, 1'b1);
        chk("t5_st_addr", st_rd_addr, 16'h0100);
`ifdef WBC_PERF_CNT_EN
        chk("t5_stall_cnt", stall_cnt, 32'd5);
        stall_clr = 1'b1;
`endif
        ker_req = 1'b0;
        tick();
`ifdef WBC_PERF_CNT_EN
        stall_clr = 1'b0;
        chk("t5_stall_clr", stall_cnt, 32'd0);
`endif
        chk("t5_rd_conf", rd_conf, 1'b1);
        ker_en = 1'b1;
        tick();
        ker_en = 1'b0;
        chk("t5_ker_done", ker_done, 1'b1);
        $display("read idx=0 after buf_idle stall st_rd_addr=%04h", st_rd_addr);

        // Address wrap at 0xFFFE with a single set.
        start_load(16'hFFFE, 8'd1);
        run_beats(16'hFFFE, 80, 1'b0);
        chk("t6_sets", sets_loaded, 8'd1);
        chk("t6_ready_fall", ddr_ready, 1'b0);
        ker_req     = 1'b1;
        ker_set_idx = 8'd0;
        tick();
        chk("t6_grant", ker_grant, 1'b1);
        chk("t6_st_addr", st_rd_addr, 16'hFFFE);
        ker_req = 1'b0;
        tick();
        chk("t6_rd_conf", rd_conf, 1'b1);

        // Mid-load reset with the read still waiting on ker_en.
        start_load(16'h0200, 8'd1);
        ddr_valid = 1'b1;
        ddr_data  = {8{32'h1234_5678}};
        tick();
        tick();
        tick();
        chk("t7_pre_wr_en", wr_en, 32'h0000_0F00);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_ready", ddr_ready, 1'b0);
        chk("t7_rst_busy", load_busy, 1'b0);
        chk("t7_rst_wr_en", wr_en, 32'h0);
        chk("t7_rst_wr_addr", wr_addr, 16'h0);
        chk("t7_rst_wr_data", wr_data, 256'h0);
        chk("t7_rst_sets", sets_loaded, 8'h0);
        chk("t7_rst_st_addr", st_rd_addr, 16'h0);
        chk("t7_rst_rd_conf", rd_conf, 1'b0);
        ddr_valid = 1'b0;
        tick();
        rst_n  = 1'b1;
        ker_en = 1'b1;
        tick();
        ker_en = 1'b0;
        chk("t7_ker_en_ignored", ker_done, 1'b0);
        tick();
        chk("t7_ker_done_still0", ker_done, 1'b0);
        chk("t7_busy_after", load_busy, 1'b0);
        $display("reset mid-load done");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/weight_buffer_ctrl.md
Name: weight_buffer_ctrl

Overview:
Controller that sequences the weight buffer.
- Load side: turns a DDR beat stream into per-bank-group write strobes and addresses.
- Read side: accepts kernel-set requests from the PE-array scheduler, blocks reads of sets not yet loaded, issues rd_conf with the set's start address, and reports completion when the buffer raises ker_en.
- Sits between the DDR read engine / PE scheduler and the weight buffer.

Parameters:
- ADDR_LEN, 16: buffer address width.
- DATA_LEN, 64: bank word width.
- DDR_DATA_LEN, 256: DDR beat width; one beat feeds GRP = DDR_DATA_LEN/DATA_LEN banks.
- BUFFER_NUM, 32: number of banks; NGRP = BUFFER_NUM/GRP bank groups.
- SET_DEPTH, 10: addresses per kernel set, matching the buffer's 10-address read burst.
- SET_W, 8: width of set counters and indices.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  start-load pulse.
- load_base  in  ADDR_LEN  first buffer address of the load.
- load_sets  in  SET_W  kernel sets to load; 0 is legal (no-op).
- ddr_valid  in  1  beat valid.
- ddr_data  in  DDR_DATA_LEN  beat data.
- ddr_ready  out  1  beat accepted when valid&ready.
- wr_data  out  DDR_DATA_LEN  to buffer data_wr.
- wr_addr  out  ADDR_LEN  to buffer wr_addr.
- wr_en  out  BUFFER_NUM  to buffer wr_en.
- load_busy  out  1  load in progress.
- sets_loaded  out  SET_W  complete sets resident.
- ker_req  in  1  kernel-set request; held until ker_grant.
- ker_set_idx  in  SET_W  requested set.
- ker_grant  out  1  one-cycle accept of the request.
- rd_conf  out  1  to buffer rd_conf.
- st_rd_addr  out  ADDR_LEN  to buffer st_rd_addr.
- buf_idle  in  1  from buffer idle.
- ker_en  in  1  from buffer ker_en.
- ker_done  out  1  one-cycle: requested set is on ker_out.
- req_err  out  1  one-cycle: request rejected (idx >= load_sets).

Behaviour:
- Reset: all outputs 0, both FSMs idle, all counters 0. Asserting rst_n low mid-operation aborts any load or read immediately; a later ker_en from the buffer is ignored while the read FSM is in R_IDLE.
- Load FSM states: L_IDLE, L_RUN.
  - L_IDLE: load_start with load_sets>0 captures base/sets, clears sets_loaded to 0, and moves to L_RUN. load_sets==0 stays in L_IDLE.
  - load_start while in L_RUN is ignored.
  - L_RUN: ddr_ready=1. Each accepted beat registers wr_data=ddr_data, wr_addr=base+addr_off, wr_en = GRP ones at bits [g*GRP +: GRP]. These outputs are valid the cycle after acceptance; wr_en is 0 in every other cycle.
  - Counters: g steps 0..NGRP-1. On wrap, addr_off increments. Every SET_DEPTH address increments sets_loaded, updated in the same cycle as the final beat's wr_en.
  - After the last beat of the last set: return to L_IDLE; ddr_ready drops in the cycle after the final acceptance.
  - Address arithmetic is modulo 2^ADDR_LEN (wraps).
- Read FSM states: R_IDLE, R_CONF, R_WAIT.
  - R_IDLE: ker_req pending.
    - idx >= load_sets (captured value): pulse req_err together with ker_grant, drop the request, stay idle.
    - Otherwise wait until idx < sets_loaded AND buf_idle. Then pulse ker_grant, register st_rd_addr = base + idx*SET_DEPTH (mod 2^ADDR_LEN), and go to R_CONF.
  - R_CONF: rd_conf=1 for exactly one cycle; go to R_WAIT.
  - R_WAIT: ignore buf_idle for the first cycle after rd_conf (the buffer's idle lags). On ker_en=1, pulse ker_done the next cycle and return to R_IDLE. A new grant is possible in the cycle ker_done is high.
  - st_rd_addr holds its value until the next grant.
- Simultaneous events:
  - load_start in the same cycle as a pending request: the load wins the capture; the request is evaluated against the new sets_loaded=0 and waits.
  - A read already in R_CONF/R_WAIT completes even if a new load starts (stale-data hazard is the scheduler's responsibility).
- Read and write never share a bank port, so load and read proceed concurrently.

Optional Feature:
- Macro: WBC_PERF_CNT_EN.
- Defined: adds output stall_cnt [31:0] and input stall_clr.
  - stall_cnt increments every cycle a request is pending in R_IDLE but not granted (waiting on load or buf_idle). It saturates at all-ones.
  - stall_clr or reset zeroes it; stall_clr wins over an increment in the same cycle.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Load 2 sets at base 0x0100 with ddr_valid held 1 -> 160 beats. wr_en cycles 0x0000000F, 0x000000F0 … 0xF0000000 per address; wr_addr runs 0x0100..0x0113; sets_loaded reaches 1 at beat 80 and 2 at beat 160; ddr_ready falls after beat 160.
- ddr_valid toggling 1-0 during the load -> no wr_en in idle cycles; same final address/strobe sequence as the first test.
- Request idx=1 issued right after load_start (2 sets) -> ker_grant only after sets_loaded=2. Then rd_conf one cycle later with st_rd_addr=0x010A. ker_done the cycle after ker_en.
- Request idx=3 with load_sets=2 -> req_err and ker_grant pulse together; no rd_conf.
- Hold buf_idle=0 with a request pending -> no grant; grant 1 cycle after buf_idle rises. With WBC_PERF_CNT_EN, stall_cnt equals the number of blocked cycles.
- Load base 0xFFFE, 1 set -> wr_addr 0xFFFE, 0xFFFF, 0x0000 … 0x0007. rst_n low mid-load -> all outputs 0 immediately, FSMs idle.
